// File: rtl/param_rs.sv
// param_rs: parametrised ALU reservation station with CDB wakeup and a registered issue port.
// Build macro RS_OLDEST_FIRST_EN: issue the oldest ready entry (age matrix) instead of the lowest index.
module param_rs #(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 3,
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int IMM_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [ROB_W-1:0]         disp_rd_tag,
  input  logic                     disp_rs1_rdy,
  input  logic [ROB_W-1:0]         disp_rs1_tag,
  input  logic [XLEN-1:0]          disp_rs1_val,
  input  logic                     disp_rs2_rdy,
  input  logic [ROB_W-1:0]         disp_rs2_tag,
  input  logic [XLEN-1:0]          disp_rs2_val,
  input  logic [IMM_W-1:0]         disp_imm,
  input  logic [31:0]              disp_pc,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_val,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [ROB_W-1:0]         iss_rd_tag,
  output logic [XLEN-1:0]          iss_rs1_val,
  output logic [XLEN-1:0]          iss_rs2_val,
  output logic [IMM_W-1:0]         iss_imm,
  output logic [31:0]              iss_pc,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] busy, rs1_rdy, rs2_rdy;
  logic [OP_W-1:0]  e_op      [DEPTH];
  logic [ROB_W-1:0] e_rd_tag  [DEPTH];
  logic [ROB_W-1:0] e_rs1_tag [DEPTH];
  logic [ROB_W-1:0] e_rs2_tag [DEPTH];
  logic [XLEN-1:0]  e_rs1_val [DEPTH];
  logic [XLEN-1:0]  e_rs2_val [DEPTH];
  logic [IMM_W-1:0] e_imm     [DEPTH];
  logic [31:0]      e_pc      [DEPTH];

  logic [DEPTH-1:0] wake1, wake2, ready_vec;
  logic [XLEN-1:0]  wake1_val [DEPTH];
  logic [XLEN-1:0]  wake2_val [DEPTH];
  logic             d1_hit, d2_hit;
  logic [XLEN-1:0]  d1_val, d2_val;
  logic [IDX_W-1:0] alloc_idx, sel_idx;
  logic             load_en, iss_fire, disp_fire;
  logic [CNT_W-1:0] free_nxt;

  function automatic logic cdb_hit(input logic [ROB_W-1:0] tag,
                                   input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*ROB_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (v[k] && (t[k*ROB_W +: ROB_W] == tag)) hit = 1'b1;
    return hit;
  endfunction

  // Scanning downward lets the lowest matching channel overwrite the others.
  function automatic logic [XLEN-1:0] cdb_data(input logic [ROB_W-1:0] tag,
                                              input logic [NUM_CDB-1:0] v,
                                              input logic [NUM_CDB*ROB_W-1:0] t,
                                              input logic [NUM_CDB*XLEN-1:0] d);
    logic [XLEN-1:0] data;
    data = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (v[k] && (t[k*ROB_W +: ROB_W] == tag)) data = d[k*XLEN +: XLEN];
    return data;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i]     = busy[i] & ~rs1_rdy[i] & cdb_hit(e_rs1_tag[i], cdb_valid, cdb_tag);
      wake2[i]     = busy[i] & ~rs2_rdy[i] & cdb_hit(e_rs2_tag[i], cdb_valid, cdb_tag);
      wake1_val[i] = cdb_data(e_rs1_tag[i], cdb_valid, cdb_tag, cdb_val);
      wake2_val[i] = cdb_data(e_rs2_tag[i], cdb_valid, cdb_tag, cdb_val);
    end
    d1_hit = cdb_hit(disp_rs1_tag, cdb_valid, cdb_tag);
    d2_hit = cdb_hit(disp_rs2_tag, cdb_valid, cdb_tag);
    d1_val = cdb_data(disp_rs1_tag, cdb_valid, cdb_tag, cdb_val);
    d2_val = cdb_data(disp_rs2_tag, cdb_valid, cdb_tag, cdb_val);
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) alloc_idx = IDX_W'(i);
  end

  assign ready_vec  = busy & rs1_rdy & rs2_rdy;
  assign disp_ready = ~full;
  assign load_en    = ~iss_valid | iss_ready;
  assign iss_fire   = load_en & (|ready_vec);
  assign disp_fire  = disp_valid & disp_ready;
  assign free_nxt   = free_cnt + CNT_W'(iss_fire) - CNT_W'(disp_fire);

`ifdef RS_OLDEST_FIRST_EN
  // age[i][j] set: entry i was dispatched before entry j.
  logic [DEPTH-1:0] age [DEPTH];

  always_comb begin
    logic [DEPTH-1:0] self_bit;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      self_bit    = '0;
      self_bit[i] = 1'b1;
      if (ready_vec[i] && ((ready_vec & ~age[i] & ~self_bit) == '0)) sel_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
        if (iss_fire) begin
          age[sel_idx] <= '0;
          for (int i = 0; i < DEPTH; i++) age[i][sel_idx] <= 1'b0;
        end
        if (disp_fire) begin
          for (int i = 0; i < DEPTH; i++) age[i][alloc_idx] <= (IDX_W'(i) != alloc_idx);
          age[alloc_idx] <= '0;
        end
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready_vec[i]) sel_idx = IDX_W'(i);
  end
`endif

  // Control state: occupancy, operand-ready flags, issue valid, free count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      rs1_rdy   <= '0;
      rs2_rdy   <= '0;
      iss_valid <= 1'b0;
      free_cnt  <= CNT_W'(DEPTH);
      full      <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        iss_valid <= 1'b0;
        free_cnt  <= CNT_W'(DEPTH);
        full      <= 1'b0;
      end else begin
        rs1_rdy <= rs1_rdy | wake1;
        rs2_rdy <= rs2_rdy | wake2;
        if (load_en) iss_valid <= |ready_vec;
        if (iss_fire) busy[sel_idx] <= 1'b0;
        if (disp_fire) begin
          busy[alloc_idx]    <= 1'b1;
          rs1_rdy[alloc_idx] <= disp_rs1_rdy | d1_hit;
          rs2_rdy[alloc_idx] <= disp_rs2_rdy | d2_hit;
        end
        free_cnt <= free_nxt;
        full     <= (free_nxt == '0);
      end
    end
  end

  // Entry payload storage; meaningful only while the entry is busy.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake1[i]) e_rs1_val[i] <= wake1_val[i];
        if (wake2[i]) e_rs2_val[i] <= wake2_val[i];
      end
      if (disp_fire) begin
        e_op[alloc_idx]      <= disp_op;
        e_rd_tag[alloc_idx]  <= disp_rd_tag;
        e_rs1_tag[alloc_idx] <= disp_rs1_tag;
        e_rs2_tag[alloc_idx] <= disp_rs2_tag;
        e_rs1_val[alloc_idx] <= disp_rs1_rdy ? disp_rs1_val : d1_val;
        e_rs2_val[alloc_idx] <= disp_rs2_rdy ? disp_rs2_val : d2_val;
        e_imm[alloc_idx]     <= disp_imm;
        e_pc[alloc_idx]      <= disp_pc;
      end
    end
  end

  // Issue stage: output register, held while the ALU stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_op      <= '0;
      iss_rd_tag  <= '0;
      iss_rs1_val <= '0;
      iss_rs2_val <= '0;
      iss_imm     <= '0;
      iss_pc      <= '0;
    end else if (rdy && !flush && iss_fire) begin
      iss_op      <= e_op[sel_idx];
      iss_rd_tag  <= e_rd_tag[sel_idx];
      iss_rs1_val <= e_rs1_val[sel_idx];
      iss_rs2_val <= e_rs2_val[sel_idx];
      iss_imm     <= e_imm[sel_idx];
      iss_pc      <= e_pc[sel_idx];
    end
  end

endmodule
